// File: rtl/rom_select_ctrl.sv
// -----------------------------------------------------------------------------
// rom_select_ctrl
//
// Front end between the board buttons and main_mem. It synchronises and
// debounces the raw buttons, keeps track of which ROM slot the user has
// selected, and requests a reload of main_mem once all buttons are released.
// If main_mem is still busy loading, the request waits until main_mem is idle.
//
// Selection modes:
//   MODE 0 (DIRECT) - the lowest pressed button number becomes the selection.
//   MODE 1 (STEP)   - button 0 steps forward, button 1 steps backward, both
//                     wrapping within 0..NUM_ROMS-1.
//
// Ports:
//   clock      in   1        system clock
//   reset      in   1        asynchronous, active-high; clears all state
//   buttons    in   NUM_BTN  raw button pins (0 = pressed when ACTIVE_LOW=1)
//   load_done  in   1        from main_mem; 1 = ROM load complete, NES running
//   pressed    out  NUM_BTN  debounced button state, 1 = pressed
//   index      out  IDX_W    ROM index to main_mem; updates only with reload
//   reload     out  1        one-cycle reload request pulse
//   pending    out  1        reload request waiting for main_mem to go idle
// -----------------------------------------------------------------------------
module rom_select_ctrl #(
    parameter int NUM_BTN         = 3,
    parameter int IDX_W           = 4,
    parameter int NUM_ROMS        = 4,
    parameter int MODE            = 0,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int INIT_INDEX      = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] buttons,
    input  logic               load_done,
    output logic [NUM_BTN-1:0] pressed,
    output logic [IDX_W-1:0]   index,
    output logic               reload,
    output logic               pending
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // Pin level of a button that is not pressed.
    localparam logic RELEASED_LEVEL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    // ------------------------------------------------------------------
    // Configuration checks
    // ------------------------------------------------------------------
    generate
        if (NUM_ROMS > (1 << IDX_W)) begin : g_bad_num_roms
            $error("rom_select_ctrl: NUM_ROMS does not fit in IDX_W bits");
        end
        if ((MODE == 0) && (NUM_BTN > (1 << IDX_W))) begin : g_bad_direct_width
            $error("rom_select_ctrl: DIRECT mode needs NUM_BTN <= 2**IDX_W");
        end
        if ((NUM_BTN < 1) || (NUM_BTN > 8)) begin : g_bad_num_btn
            $error("rom_select_ctrl: NUM_BTN must be 1..8");
        end
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
            $error("rom_select_ctrl: DEBOUNCE_CYCLES must be >= 1");
        end
        if ((INIT_INDEX < 0) || (INIT_INDEX >= NUM_ROMS)) begin : g_bad_init
            $error("rom_select_ctrl: INIT_INDEX must be below NUM_ROMS");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Per-button synchroniser and debouncer
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] pressed_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            logic             sync_a_reg;
            logic             sync_b_reg;
            logic             synced;
            logic [CNT_W-1:0] stable_cnt_reg;
            logic             state_reg;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    sync_a_reg <= RELEASED_LEVEL;
                    sync_b_reg <= RELEASED_LEVEL;
                end else begin
                    sync_a_reg <= buttons[gi];
                    sync_b_reg <= sync_a_reg;
                end
            end

            // Normalise to 1 = pressed after the synchroniser.
            assign synced = (ACTIVE_LOW != 0) ? ~sync_b_reg : sync_b_reg;

            // The counter measures how long the synced level has disagreed
            // with the debounced state. Toggling on the edge where it would
            // reach DEBOUNCE_CYCLES gives a total raw-edge latency of
            // 2 + DEBOUNCE_CYCLES clocks.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    stable_cnt_reg <= '0;
                    state_reg      <= 1'b0;
                end else if (synced == state_reg) begin
                    stable_cnt_reg <= '0;
                end else if (stable_cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_reg      <= ~state_reg;
                    stable_cnt_reg <= '0;
                end else begin
                    stable_cnt_reg <= stable_cnt_reg + CNT_W'(1);
                end
            end

            assign pressed_reg[gi] = state_reg;
        end
    endgenerate

    assign pressed = pressed_reg;

    // Previous debounced state, for edge and release detection.
    logic [NUM_BTN-1:0] pressed_prev_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pressed_prev_reg <= '0;
        end else begin
            pressed_prev_reg <= pressed_reg;
        end
    end

    // All buttons just went from "some pressed" to "none pressed".
    logic release_evt;
    assign release_evt = (|pressed_prev_reg) && !(|pressed_reg);

    // ------------------------------------------------------------------
    // ROM selection
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] sel_reg;
    logic [IDX_W-1:0] sel_next;

    generate
        if (MODE == 0) begin : g_direct
            // Scan from the top so the lowest pressed button wins.
            always_comb begin
                sel_next = sel_reg;
                for (int i = NUM_BTN - 1; i >= 0; i--) begin
                    if (pressed_reg[i]) begin
                        sel_next = IDX_W'(i);
                    end
                end
            end
        end else begin : g_step
            // Only buttons 0 and 1 steer; padding keeps NUM_BTN=1 legal.
            logic [1:0] step_now;
            logic [1:0] step_prev;
            logic [1:0] step_rise;

            assign step_now  = 2'(pressed_reg);
            assign step_prev = 2'(pressed_prev_reg);
            assign step_rise = step_now & ~step_prev;

            always_comb begin
                sel_next = sel_reg;
                if (step_rise[0]) begin
                    sel_next = (sel_reg == IDX_W'(NUM_ROMS - 1)) ? '0
                                                                 : sel_reg + IDX_W'(1);
                end else if (step_rise[1]) begin
                    sel_next = (sel_reg == '0) ? IDX_W'(NUM_ROMS - 1)
                                               : sel_reg - IDX_W'(1);
                end
            end
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel_reg <= IDX_W'(INIT_INDEX);
        end else begin
            sel_reg <= sel_next;
        end
    end

    // ------------------------------------------------------------------
    // Reload handshake with main_mem
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        WAIT_LO = 2'd2,
        WAIT_HI = 2'd3
    } state_t;

    state_t     state_reg;
    logic       req_reg;
    logic [3:0] timer_reg;

    logic go_pulse;
    logic req_next;

    assign go_pulse = (state_reg == IDLE) && req_reg && load_done;
    // The request is sticky; the PULSE cycle consumes it, but a release
    // arriving in that same cycle re-arms it.
    assign req_next = release_evt || (req_reg && (state_reg != PULSE));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            req_reg   <= 1'b0;
            timer_reg <= '0;
            reload    <= 1'b0;
            pending   <= 1'b0;
            index     <= IDX_W'(INIT_INDEX);
        end else begin
            reload  <= 1'b0;
            req_reg <= req_next;
            pending <= req_next && !go_pulse;
            case (state_reg)
                IDLE: begin
                    if (go_pulse) begin
                        state_reg <= PULSE;
                        reload    <= 1'b1;
                        index     <= sel_reg;
                    end
                end
                PULSE: begin
                    state_reg <= WAIT_LO;
                    timer_reg <= '0;
                end
                WAIT_LO: begin
                    // If main_mem never drops load_done, assume it ignored
                    // the pulse and give up after 16 cycles.
                    if (!load_done) begin
                        state_reg <= WAIT_HI;
                    end else if (timer_reg == 4'd15) begin
                        state_reg <= IDLE;
                    end else begin
                        timer_reg <= timer_reg + 4'd1;
                    end
                end
                WAIT_HI: begin
                    if (load_done) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
